// File: rtl/generic_bus_arb_pkg.sv
// Shared types for the two-master generic bus arbiter.
// Bus widths and owner encoding live here so future N-master versions can reuse them.
package generic_bus_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } arb_state_t;

   typedef logic owner_t;

   localparam owner_t REQ0 = 1'b0;
   localparam owner_t REQ1 = 1'b1;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int BE_W   = 4;

endpackage

// File: rtl/generic_bus_if.sv
// Generic bus: requester drives addr/wdata/ren/wen/byte_en,
// responder returns rdata/busy.
interface generic_bus_if;
   import generic_bus_arb_pkg::*;

   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ren;
   logic              wen;
   logic              busy;
   logic [BE_W-1:0]   byte_en;

   modport generic_bus (
      input  addr, wdata, ren, wen, byte_en,
      output rdata, busy
   );

   modport cpu (
      output addr, wdata, ren, wen, byte_en,
      input  rdata, busy
   );

endinterface

// File: rtl/rr_pick2.sv
// Two-way pick: round-robin on a tie, or req0-first when FIXED_PRIORITY.
// Purely combinational; the caller registers the result.
module rr_pick2
   import generic_bus_arb_pkg::*;
#(
   parameter bit FIXED_PRIORITY = 1'b0
) (
   input  logic [1:0] req_i,
   input  owner_t     last_grant_i,
   output logic       valid_o,
   output owner_t     winner_o
);

   always_comb begin
      valid_o  = |req_i;
      winner_o = REQ0;
      unique case (req_i)
         2'b01:   winner_o = REQ0;
         2'b10:   winner_o = REQ1;
         2'b11: begin
            if (FIXED_PRIORITY)
               winner_o = REQ0;
            else
               winner_o = ~last_grant_i;
         end
         default: winner_o = REQ0;
      endcase
   end

endmodule

// File: rtl/generic_bus_arbiter.sv
// Shares one generic bus between two masters, locking it per transaction
// and always inserting one IDLE cycle between grants.
module generic_bus_arbiter
   import generic_bus_arb_pkg::*;
#(
   parameter bit FIXED_PRIORITY = 1'b0
) (
   input  logic                   CLK,
   input  logic                   nRST,
   generic_bus_if.generic_bus     req0_gen_bus_if,
   generic_bus_if.generic_bus     req1_gen_bus_if,
   generic_bus_if.cpu             out_gen_bus_if
);

   arb_state_t state_q, state_d;
   owner_t     owner_q, owner_d;
   owner_t     last_grant_q, last_grant_d;

   logic   req0;
   logic   req1;
   logic   own_req;
   logic   fwd;
   logic   pick_valid;
   owner_t pick_winner;

   assign req0 = req0_gen_bus_if.ren | req0_gen_bus_if.wen;
   assign req1 = req1_gen_bus_if.ren | req1_gen_bus_if.wen;
   assign own_req = (owner_q == REQ1) ? req1 : req0;

   rr_pick2 #(
      .FIXED_PRIORITY (FIXED_PRIORITY)
   ) u_pick (
      .req_i        ({req1, req0}),
      .last_grant_i (last_grant_q),
      .valid_o      (pick_valid),
      .winner_o     (pick_winner)
   );

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q      <= IDLE;
         owner_q      <= REQ0;
         last_grant_q <= REQ1;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Abandon and completion both hand the turn to the other master.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      fwd          = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d = OWNED;
               owner_d = pick_winner;
            end
         end
         OWNED: begin
            fwd = 1'b1;
            if (!own_req || !out_gen_bus_if.busy) begin
               state_d      = IDLE;
               last_grant_d = owner_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   logic sel0;
   logic sel1;

   assign sel0 = fwd && (owner_q == REQ0);
   assign sel1 = fwd && (owner_q == REQ1);

   assign out_gen_bus_if.ren =
      (sel0 & req0_gen_bus_if.ren) | (sel1 & req1_gen_bus_if.ren);
   assign out_gen_bus_if.wen =
      (sel0 & req0_gen_bus_if.wen) | (sel1 & req1_gen_bus_if.wen);

   assign out_gen_bus_if.addr =
      sel0 ? req0_gen_bus_if.addr :
      sel1 ? req1_gen_bus_if.addr : '0;
   assign out_gen_bus_if.wdata =
      sel0 ? req0_gen_bus_if.wdata :
      sel1 ? req1_gen_bus_if.wdata : '0;
   assign out_gen_bus_if.byte_en =
      sel0 ? req0_gen_bus_if.byte_en :
      sel1 ? req1_gen_bus_if.byte_en : '0;

   assign req0_gen_bus_if.busy = sel0 ? out_gen_bus_if.busy : 1'b1;
   assign req1_gen_bus_if.busy = sel1 ? out_gen_bus_if.busy : 1'b1;

   assign req0_gen_bus_if.rdata = out_gen_bus_if.rdata;
   assign req1_gen_bus_if.rdata = out_gen_bus_if.rdata;

endmodule

// File: tb/tb_generic_bus_arbiter.sv
// Directed bench: a per-cycle vector table for the round-robin arbiter
// plus a hand-written sequence for the fixed-priority variant.
module tb_generic_bus_arbiter;

   logic CLK = 1'b0;
   logic rst_a;
   logic rst_b;

   always #5 CLK = ~CLK;

   generic_bus_if a0_if();
   generic_bus_if a1_if();
   generic_bus_if ao_if();
   generic_bus_if b0_if();
   generic_bus_if b1_if();
   generic_bus_if bo_if();

   generic_bus_arbiter #(
      .FIXED_PRIORITY (1'b0)
   ) dut_rr (
      .CLK             (CLK),
      .nRST            (rst_a),
      .req0_gen_bus_if (a0_if.generic_bus),
      .req1_gen_bus_if (a1_if.generic_bus),
      .out_gen_bus_if  (ao_if.cpu)
   );

   generic_bus_arbiter #(
      .FIXED_PRIORITY (1'b1)
   ) dut_fp (
      .CLK             (CLK),
      .nRST            (rst_b),
      .req0_gen_bus_if (b0_if.generic_bus),
      .req1_gen_bus_if (b1_if.generic_bus),
      .out_gen_bus_if  (bo_if.cpu)
   );

   typedef struct {
      logic        rst;
      logic        r0r;
      logic        r0w;
      logic [31:0] r0a;
      logic [31:0] r0d;
      logic        r1r;
      logic        r1w;
      logic [31:0] r1a;
      logic [31:0] r1d;
      logic        ob;
      logic [31:0] ord;
      logic        er;
      logic        ew;
      logic [31:0] ea;
      logic [31:0] ed;
      logic [3:0]  ebe;
      logic        eb0;
      logic        eb1;
   } vec_t;

   localparam logic [31:0] A0 = 32'h8000_0010;
   localparam logic [31:0] A1 = 32'h0000_0100;
   localparam logic [31:0] A2 = 32'h0000_0200;
   localparam logic [31:0] A3 = 32'h0000_0300;
   localparam logic [31:0] A4 = 32'h0000_0400;
   localparam logic [31:0] DB = 32'hDEAD_BEEF;
   localparam logic [31:0] D0 = 32'h0000_0011;
   localparam logic [31:0] D1 = 32'h0000_0022;
   localparam int NV = 27;

   vec_t tbl [NV];
   int   checks = 0;
   int   errors = 0;

   initial begin
      // rst r0r r0w r0a r0d r1r r1w r1a r1d ob ord | er ew ea ed be b0 b1
      tbl[0]  = '{0,0,0,0,0,0,0,0,0,1,0,   0,0,0,0,0,1,1};
      tbl[1]  = '{0,0,0,0,0,0,0,0,0,1,0,   0,0,0,0,0,1,1};
      tbl[2]  = '{0,1,0,A0,0,0,0,0,0,1,0,  0,0,0,0,0,1,1};
      tbl[3]  = '{1,1,0,A0,0,0,0,0,0,1,0,  0,0,0,0,0,1,1};
      tbl[4]  = '{1,1,0,A0,0,0,0,0,0,1,0,  1,0,A0,0,4'hF,1,1};
      tbl[5]  = '{1,1,0,A0,0,0,0,0,0,1,0,  1,0,A0,0,4'hF,1,1};
      tbl[6]  = '{1,1,0,A0,0,0,0,0,0,0,DB, 1,0,A0,0,4'hF,0,1};
      tbl[7]  = '{1,0,0,0,0,0,0,0,0,1,0,   0,0,0,0,0,1,1};
      tbl[8]  = '{1,0,1,A1,D0,0,1,A2,D1,0,0, 0,0,0,0,0,1,1};
      tbl[9]  = '{1,0,1,A1,D0,0,1,A2,D1,0,0, 0,1,A2,D1,4'h3,1,0};
      tbl[10] = '{1,0,1,A1,D0,0,1,A2,D1,0,0, 0,0,0,0,0,1,1};
      tbl[11] = '{1,0,1,A1,D0,0,1,A2,D1,0,0, 0,1,A1,D0,4'hF,0,1};
      tbl[12] = '{1,0,1,A1,D0,0,1,A2,D1,0,0, 0,0,0,0,0,1,1};
      tbl[13] = '{1,0,1,A1,D0,0,1,A2,D1,0,0, 0,1,A2,D1,4'h3,1,0};
      tbl[14] = '{1,0,1,A1,D0,0,1,A2,D1,0,0, 0,0,0,0,0,1,1};
      tbl[15] = '{1,0,1,A1,D0,0,1,A2,D1,0,0, 0,1,A1,D0,4'hF,0,1};
      tbl[16] = '{1,1,0,A3,0,1,0,A4,0,1,0,  0,0,0,0,0,1,1};
      tbl[17] = '{1,1,0,A3,0,1,0,A4,0,1,0,  1,0,A4,0,4'h3,1,1};
      tbl[18] = '{1,1,0,A3,0,0,0,A4,0,1,0,  0,0,A4,0,4'h3,1,1};
      tbl[19] = '{1,1,0,A3,0,0,0,A4,0,1,0,  0,0,0,0,0,1,1};
      tbl[20] = '{1,1,0,A3,0,0,0,A4,0,0,0,  1,0,A3,0,4'hF,0,1};
      tbl[21] = '{1,1,0,A3,0,0,0,A4,0,1,0,  0,0,0,0,0,1,1};
      tbl[22] = '{1,1,0,A3,0,0,0,A4,0,1,0,  1,0,A3,0,4'hF,1,1};
      tbl[23] = '{0,1,0,A3,0,0,0,A4,0,1,0,  1,0,A3,0,4'hF,1,1};
      tbl[24] = '{1,1,0,A3,0,1,0,A4,0,1,0,  0,0,0,0,0,1,1};
      tbl[25] = '{1,1,0,A3,0,1,0,A4,0,0,0,  1,0,A3,0,4'hF,0,1};
      tbl[26] = '{1,0,0,0,0,0,0,0,0,1,0,   0,0,0,0,0,1,1};
   end

   task automatic idle_b();
      b0_if.ren = 0; b0_if.wen = 0;
      b0_if.addr = 0; b0_if.wdata = 0;
      b0_if.byte_en = 4'hF;
      b1_if.ren = 0; b1_if.wen = 0;
      b1_if.addr = 0; b1_if.wdata = 0;
      b1_if.byte_en = 4'h3;
      bo_if.busy = 1; bo_if.rdata = 0;
   endtask

   task automatic apply(input vec_t v);
      rst_a = v.rst;
      a0_if.ren = v.r0r; a0_if.wen = v.r0w;
      a0_if.addr = v.r0a; a0_if.wdata = v.r0d;
      a0_if.byte_en = 4'hF;
      a1_if.ren = v.r1r; a1_if.wen = v.r1w;
      a1_if.addr = v.r1a; a1_if.wdata = v.r1d;
      a1_if.byte_en = 4'h3;
      ao_if.busy = v.ob; ao_if.rdata = v.ord;
   endtask

   initial begin
      vec_t idle;
      idle = '{0,0,0,0,0,0,0,0,0,1,0, 0,0,0,0,0,1,1};
      rst_b = 0;
      idle_b();
      apply(idle);
      repeat (2) @(posedge CLK);

      for (int k = 0; k < NV; k++) begin
         @(posedge CLK);
         #1;
         apply(tbl[k]);
         @(negedge CLK);
         checks++;
         if (ao_if.ren !== tbl[k].er || ao_if.wen !== tbl[k].ew ||
             ao_if.addr !== tbl[k].ea || ao_if.wdata !== tbl[k].ed ||
             ao_if.byte_en !== tbl[k].ebe ||
             a0_if.busy !== tbl[k].eb0 || a1_if.busy !== tbl[k].eb1 ||
             a0_if.rdata !== tbl[k].ord || a1_if.rdata !== tbl[k].ord) begin
            errors++;
            $display("FAIL vec%0d got ren=%b wen=%b addr=%h wd=%h be=%h b0=%b b1=%b rd0=%h rd1=%h want ren=%b wen=%b addr=%h wd=%h be=%h b0=%b b1=%b rd=%h",
               k, ao_if.ren, ao_if.wen, ao_if.addr, ao_if.wdata,
               ao_if.byte_en, a0_if.busy, a1_if.busy,
               a0_if.rdata, a1_if.rdata,
               tbl[k].er, tbl[k].ew, tbl[k].ea, tbl[k].ed,
               tbl[k].ebe, tbl[k].eb0, tbl[k].eb1, tbl[k].ord);
         end
      end

      // Fixed priority: req0 keeps winning until it drops its request.
      @(posedge CLK);
      #1;
      rst_b = 1;
      b0_if.wen = 1; b0_if.addr = A1; b0_if.wdata = D0;
      b1_if.wen = 1; b1_if.addr = A2; b1_if.wdata = D1;
      bo_if.busy = 0;
      for (int s = 0; s < 8; s++) begin
         logic        xw;
         logic [31:0] xd;
         logic        xb1;
         if (s == 6) begin
            b0_if.wen = 0;
            b0_if.addr = 0;
            b0_if.wdata = 0;
         end
         xw  = (s % 2) == 1;
         xd  = (s == 7) ? D1 : (xw ? D0 : 32'h0);
         xb1 = (s == 7) ? 1'b0 : 1'b1;
         @(negedge CLK);
         checks++;
         if (bo_if.wen !== xw || bo_if.wdata !== xd ||
             b1_if.busy !== xb1) begin
            errors++;
            $display("FAIL fp_step%0d got wen=%b wd=%h b1=%b want wen=%b wd=%h b1=%b",
               s, bo_if.wen, bo_if.wdata, b1_if.busy, xw, xd, xb1);
         end
         @(posedge CLK);
         #1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
